// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Also provides flush-to-bubble and saturating bubble/stall performance counters.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W    = 128,
  parameter logic [DATA_W-1:0]  NOP_DATA  = '0,
  parameter logic [31:0]        NOP_INSTR = 32'h0000_0013,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_instr,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned INSTR_W = 32;

  // State is the pair {skid_valid, main_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

  logic               main_valid, main_valid_n;
  logic [DATA_W-1:0]  main_data,  main_data_n;
  logic [INSTR_W-1:0] main_instr, main_instr_n;
  logic               skid_valid, skid_valid_n;
  logic [DATA_W-1:0]  skid_data,  skid_data_n;
  logic [INSTR_W-1:0] skid_instr, skid_instr_n;
  logic [CNT_W-1:0]   bubble_q,   bubble_n;
  logic [CNT_W-1:0]   stall_q,    stall_n;

  logic       in_fire;
  logic       out_fire;
  logic [1:0] state;

  // in_ready depends only on a flop, never on same-cycle downstream signals
  assign in_ready   = ~skid_valid;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = main_valid & out_ready;
  assign state      = {skid_valid, main_valid};

  assign out_valid  = main_valid;
  assign out_data   = main_data;
  assign out_instr  = main_instr;
  assign occupancy  = 2'(main_valid) + 2'(skid_valid);
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;

  // Next-state and datapath selection
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    main_instr_n = main_instr;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_instr_n = skid_instr;

    if (flush) begin
      main_valid_n = 1'b0;
      main_data_n  = NOP_DATA;
      main_instr_n = NOP_INSTR;
      skid_valid_n = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_valid_n = 1'b1;
            main_data_n  = in_data;
            main_instr_n = in_instr;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_n  = in_data;
            main_instr_n = in_instr;
          end else if (out_fire) begin
            main_valid_n = 1'b0;
            main_data_n  = NOP_DATA;
            main_instr_n = NOP_INSTR;
          end else if (in_fire) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
            skid_instr_n = in_instr;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_data_n  = skid_data;
            main_instr_n = skid_instr;
            skid_valid_n = 1'b0;
          end
        end
        default: begin
          // Skid without main cannot arise; recover to empty
          main_valid_n = 1'b0;
          main_data_n  = NOP_DATA;
          main_instr_n = NOP_INSTR;
          skid_valid_n = 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters, clear has priority
  always_comb begin
    bubble_n = bubble_q;
    stall_n  = stall_q;
    if (cnt_clr) begin
      bubble_n = '0;
      stall_n  = '0;
    end else begin
      if (out_ready && !main_valid && (bubble_q != {CNT_W{1'b1}}))
        bubble_n = bubble_q + CNT_W'(1);
      if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
        stall_n = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= NOP_DATA;
      main_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_data  <= NOP_DATA;
      skid_instr <= NOP_INSTR;
      bubble_q   <= '0;
      stall_q    <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      main_instr <= main_instr_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_instr <= skid_instr_n;
      bubble_q   <= bubble_n;
      stall_q    <= stall_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: latency, streaming, skid
// back-pressure, flush, counter saturation/clear and asynchronous reset.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 4;
  localparam logic [31:0] NOP_I  = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [31:0]       in_instr = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       out_instr;
  logic [1:0]        occupancy;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_instr(in_instr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_instr(out_instr),
    .occupancy(occupancy), .cnt_clr(cnt_clr),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_instr = 32'h0000_1000 | d[31:0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #3 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occ", occupancy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_instr", out_instr, NOP_I);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_stall", stall_cnt, 0);
    step();
    step();
    rst = 1'b0;

    // Single word, 1-cycle latency
    in_valid = 1'b1; in_data = 'hA1; in_instr = 32'h0050_0093; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 'hA1);
    check("lat_instr", out_instr, 32'h0050_0093);
    check("lat_occ", occupancy, 1);
    step();
    check("drain_valid", out_valid, 0);
    check("drain_nop_data", out_data, 0);
    check("drain_nop_instr", out_instr, NOP_I);

    // Stream 8 words at full rate
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_stall", stall_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      offer(DATA_W'(32'h10 + i));
      check("stream_in_ready", in_ready, 1);
      step();
      check("stream_data", out_data, DATA_W'(32'h10 + i));
      check("stream_instr", out_instr, 32'h0000_1010 + 32'(i));
      check("stream_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_stall", stall_cnt, 0);
    check("stream_empty", occupancy, 0);

    // Skid back-pressure and ordering
    out_ready = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    offer('h20);
    step();
    check("bp_occ1", occupancy, 1);
    offer('h21);
    step();
    check("bp_occ2", occupancy, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_head", out_data, 'h20);
    offer('h22);
    step();
    check("bp_reject_occ", occupancy, 2);
    check("bp_head_hold", out_data, 'h20);
    step();
    check("bp_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    step();
    check("bp_second", out_data, 'h21);
    check("bp_in_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_third", out_data, 'h22);
    step();
    check("bp_done", out_valid, 0);
    check("bp_stall_final", stall_cnt, 3);

    // Flush with occupancy 2 and a concurrent offer
    out_ready = 1'b0;
    offer('h40);
    step();
    offer('h41);
    step();
    check("fl_occ2", occupancy, 2);
    flush = 1'b1; out_ready = 1'b1;
    offer('h30);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_instr", out_instr, NOP_I);
    check("fl_data", out_data, 0);
    check("fl_occ", occupancy, 0);
    check("fl_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no_ghost", out_valid, 0);
    end

    // Bubble counter saturation and clear priority
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("sat_clr0", bubble_cnt, 0);
    for (int i = 0; i < 14; i++) step();
    check("sat_14", bubble_cnt, 14);
    for (int i = 0; i < 6; i++) step();
    check("sat_15", bubble_cnt, 15);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("sat_clr_wins", bubble_cnt, 0);

    // Asynchronous reset mid-cycle with two entries
    out_ready = 1'b0;
    offer('h60);
    step();
    offer('h61);
    step();
    in_valid = 1'b0;
    check("ar_occ2", occupancy, 2);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_occ", occupancy, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_data", out_data, 0);
    check("ar_instr", out_instr, NOP_I);
    check("ar_stall", stall_cnt, 0);
    #3 rst = 1'b0;
    step();
    offer('h50); out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("ar_first_valid", out_valid, 1);
    check("ar_first_data", out_data, 'h50);
    step();
    check("ar_drained", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
